dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 86 ++++++++
 tb/tb_dmem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage and a loader/debug master.
//   p_*  : pipeline request (byte-lane read/write masks), p_stall holds it, p_rdata returns data
//   l_*  : loader request, l_gnt marks a performed access, l_rdata returns data
//   m_*  : data-memory port, m_rdata is combinational from m_addr/m_read
//   Pipeline owns memory by default; the loader takes over when the pipeline is idle or has
//   starved it for STARVE_LIMIT cycles, and hands back after BURST_MAX accesses against a waiting pipeline.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned BURST_MAX    = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] p_addr,
  input  logic [3:0]  p_read,
  input  logic [3:0]  p_write,
  input  logic [31:0] p_wdata,
  output logic        p_stall,
  output logic [31:0] p_rdata,
  input  logic        l_req,
  input  logic [10:0] l_addr,
  input  logic [3:0]  l_read,
  input  logic [3:0]  l_write,
  input  logic [31:0] l_wdata,
  output logic        l_gnt,
  output logic [31:0] l_rdata,
  output logic [10:0] m_addr,
  output logic [3:0]  m_read,
  output logic [3:0]  m_write,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata
);
  typedef enum logic {P_OWN, L_OWN} state_t;
  localparam logic [7:0] WAIT_TOP  = 8'(STARVE_LIMIT - 1);
  localparam logic [7:0] BURST_TOP = 8'(BURST_MAX - 1);
  state_t     state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt, burst_cnt, burst_nxt;
  logic       p_req;
  assign p_req   = (p_read != 4'h0) || (p_write != 4'h0);
  assign p_rdata = m_rdata;
  assign l_rdata = m_rdata;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= P_OWN;
      wait_cnt  <= 8'd0;
      burst_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      burst_cnt <= burst_nxt;
    end
  always_comb begin
    state_nxt = state;
    wait_nxt  = 8'd0;
    burst_nxt = 8'd0;
    m_addr    = p_addr;
    m_read    = p_read;
    m_write   = p_write;
    m_wdata   = p_wdata;
    l_gnt     = 1'b0;
    p_stall   = 1'b0;
    if (state == P_OWN) begin
      if (l_req && (!p_req || wait_cnt == WAIT_TOP))
        state_nxt = L_OWN;
      else if (l_req && p_req)
        wait_nxt = (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
    end else begin
      m_addr    = l_addr;
      m_read    = l_req ? l_read : 4'h0;
      m_write   = l_req ? l_write : 4'h0;
      m_wdata   = l_wdata;
      l_gnt     = l_req;
      p_stall   = p_req;
      // only accesses made while the pipeline waits count toward the burst limit
      burst_nxt = (l_req && p_req && burst_cnt != 8'hFF) ? burst_cnt + 8'd1 : burst_cnt;
      if (!l_req || (p_req && burst_cnt == BURST_TOP))
        state_nxt = P_OWN;
    end
    // strobes and handshakes drop as soon as reset asserts, without waiting for a clock
    if (!reset_n) begin
      m_read  = 4'h0;
      m_write = 4'h0;
      l_gnt   = 1'b0;
      p_stall = 1'b0;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter; cycle n is the period ending at rising edge n,
// with stimulus applied just after edge 0.
module tb_dmem_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [10:0] p_addr, l_addr, m_addr;
  logic [3:0]  p_read, p_write, l_read, l_write, m_read, m_write;
  logic [31:0] p_wdata, l_wdata, m_wdata, m_rdata, p_rdata, l_rdata;
  logic        p_stall, l_req, l_gnt;
  int          checks = 0;
  int          errors = 0;
  int          n;

  always #5 clk = ~clk;

  assign m_rdata = (m_read != 4'h0) ? {5'h0, m_addr, 16'hA5C3} : 32'h0;

  dmem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .p_addr(p_addr), .p_read(p_read), .p_write(p_write), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata),
    .l_req(l_req), .l_addr(l_addr), .l_read(l_read), .l_write(l_write), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rdata(l_rdata),
    .m_addr(m_addr), .m_read(m_read), .m_write(m_write), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic drop_all();
    p_read = 4'h0; p_write = 4'h0; l_req = 1'b0; l_read = 4'h0; l_write = 4'h0;
  endtask

  initial begin
    reset_n = 1'b0;
    p_addr = 11'h010; p_read = 4'hF; p_write = 4'hF; p_wdata = 32'h1234_5678;
    l_req = 1'b1; l_addr = 11'h011; l_read = 4'hF; l_write = 4'hF; l_wdata = 32'h0;
    #12;
    check("rst_m_read", 32'(m_read), 32'h0);
    check("rst_m_write", 32'(m_write), 32'h0);
    check("rst_l_gnt", 32'(l_gnt), 32'h0);
    check("rst_p_stall", 32'(p_stall), 32'h0);
    drop_all();
    @(negedge clk) reset_n = 1'b1;

    // pipeline-only write passes straight through
    @(posedge clk); #1;
    p_write = 4'hF; p_addr = 11'h010; p_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("p_only_write", 32'(m_write), 32'hF);
      check("p_only_addr", 32'(m_addr), 32'h010);
      check("p_only_wdata", m_wdata, 32'hDEADBEEF);
      check("p_only_stall", 32'(p_stall), 32'h0);
    end
    @(posedge clk); #1;
    drop_all();

    // loader-only: three reads, granted in cycle 2
    @(posedge clk); #1;
    l_req = 1'b1; l_read = 4'hF; l_addr = 11'h020;
    n = 1;
    @(negedge clk);
    while (!l_gnt && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("l_only_first_gnt", 32'(n), 32'd2);
    for (int k = 0; k < 3; k++) begin
      check("l_only_gnt", 32'(l_gnt), 32'h1);
      check("l_only_rdata", l_rdata, {5'h0, 11'h020 + 11'(k), 16'hA5C3});
      check("l_only_m_read", 32'(m_read), 32'hF);
      @(posedge clk); #1;
      if (k < 2) l_addr = l_addr + 11'd1;
      else drop_all();
      @(negedge clk);
    end
    check("l_only_release", 32'(l_gnt), 32'h0);

    // pipeline busy every cycle: loader starves until cycle 9, then bursts 4 accesses
    @(posedge clk); #1;
    p_read = 4'hF; p_addr = 11'h030;
    l_req = 1'b1; l_write = 4'hF; l_addr = 11'h040; l_wdata = 32'hCAFE_0001;
    n = 1;
    @(negedge clk);
    while (!l_gnt && n < 30) begin
      check("starve_m_read", 32'(m_read), 32'hF);
      n++;
      @(negedge clk);
    end
    check("starve_first_gnt", 32'(n), 32'd9);
    check("starve_p_stall", 32'(p_stall), 32'h1);
    check("starve_m_write", 32'(m_write), 32'hF);
    check("starve_m_addr", 32'(m_addr), 32'h040);
    n = 1;
    @(negedge clk);
    while (l_gnt && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("burst_len", 32'(n), 32'd4);
    check("burst_back_stall", 32'(p_stall), 32'h0);
    check("burst_back_m_read", 32'(m_read), 32'hF);
    check("burst_back_m_addr", 32'(m_addr), 32'h030);
    @(posedge clk); #1;
    drop_all();
    @(posedge clk); #1;

    // loader with idle pipeline is unbounded; burst limit starts once the pipeline asks
    l_req = 1'b1; l_write = 4'h3; l_addr = 11'h050; l_wdata = 32'h0000_00AA;
    @(negedge clk);
    check("idle_cycle1_gnt", 32'(l_gnt), 32'h0);
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (l_gnt) n++;
    end
    check("idle_grants", 32'(n), 32'd12);
    @(posedge clk); #1;
    p_write = 4'h1; p_addr = 11'h070;
    n = 0;
    @(negedge clk);
    while (p_stall && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("stall_len", 32'(n), 32'd4);
    check("stall_end_gnt", 32'(l_gnt), 32'h0);
    check("stall_end_m_write", 32'(m_write), 32'h1);
    @(posedge clk); #1;
    drop_all();
    @(posedge clk); #1;

    // reset pulsed during the second loader grant
    l_req = 1'b1; l_write = 4'hF; l_addr = 11'h060; l_wdata = 32'h5555_AAAA;
    @(negedge clk);
    check("rb_cycle1_gnt", 32'(l_gnt), 32'h0);
    @(negedge clk);
    check("rb_first_gnt", 32'(l_gnt), 32'h1);
    @(posedge clk); #2;
    p_write = 4'h2; p_addr = 11'h0AB;
    #1;
    check("rb_second_gnt", 32'(l_gnt), 32'h1);
    check("rb_second_stall", 32'(p_stall), 32'h1);
    reset_n = 1'b0;
    #1;
    check("rb_rst_m_write", 32'(m_write), 32'h0);
    check("rb_rst_l_gnt", 32'(l_gnt), 32'h0);
    check("rb_rst_p_stall", 32'(p_stall), 32'h0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    #1;
    check("rb_post_l_gnt", 32'(l_gnt), 32'h0);
    check("rb_post_m_write", 32'(m_write), 32'h2);
    check("rb_post_m_addr", 32'(m_addr), 32'h0AB);
    check("rb_post_p_stall", 32'(p_stall), 32'h0);
    @(posedge clk); #1;
    drop_all();
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
